// File: rtl/uvma_obi_memory_arb_pkg.sv
// Shared types and helpers for the OBI memory round-robin arbiter.
package uvma_obi_memory_arb_pkg;

  localparam int unsigned ARB_MAX_REQ         = 8;
  localparam int unsigned ARB_IDX_W           = $clog2(ARB_MAX_REQ);
  localparam int unsigned ARB_MAX_OUTSTANDING = 16;
  localparam int unsigned ARB_CNT_W           = $clog2(ARB_MAX_OUTSTANDING + 1);

  // One ID FIFO entry: index of the master that owns an accepted request.
  typedef logic [ARB_IDX_W-1:0] arb_id_t;

  // First requesting index scanning upward from (last+1) mod n.
  // With no requester the result is (last+1) mod n, which is harmless
  // because the caller qualifies it with the request bit.
  function automatic arb_id_t rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                      input arb_id_t                last,
                                      input int unsigned            n);
    arb_id_t     pick;
    arb_id_t     cand;
    logic        found;
    int unsigned idx;
    idx   = (32'(last) + 1) % n;
    pick  = arb_id_t'(idx);
    found = 1'b0;
    for (int unsigned i = 1; i <= ARB_MAX_REQ; i++) begin
      if (i <= n && !found) begin
        idx  = (32'(last) + i) % n;
        cand = arb_id_t'(idx);
        if (req[cand]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uvma_obi_memory_arb_id_fifo.sv
// In-order FIFO of granted master IDs used to route R-channel responses.
module uvma_obi_memory_arb_id_fifo
  import uvma_obi_memory_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  arb_id_t          push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output arb_id_t          head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;

  // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/uvma_obi_memory_rr_arbiter.sv
// Round-robin OBI A-channel arbiter with in-order R-channel routing,
// outstanding tracking and sticky slave-side protocol error flag.
module uvma_obi_memory_rr_arbiter
  import uvma_obi_memory_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  input  logic [NUM_REQ-1:0]              rready_i,
  output logic                            m_req_o,
  input  logic                            m_gnt_i,
  output logic [ADDR_WIDTH-1:0]           m_addr_o,
  output logic                            m_we_o,
  output logic [DATA_WIDTH/8-1:0]         m_be_o,
  output logic [DATA_WIDTH-1:0]           m_wdata_o,
  input  logic                            m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           m_rdata_i,
  output logic                            m_rready_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                            err_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_id_t          last_q;
  arb_id_t          lock_idx_q;
  logic             lock_q;
  logic             err_q;
  arb_id_t          sel;
  arb_id_t          head;
  logic             sel_req;
  logic             accept;
  logic             pop;
  logic             rready_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Pick the master: a stalled request stays pinned until granted.
  always_comb begin
    sel = lock_q ? lock_idx_q : rr_pick(ARB_MAX_REQ'(req_i), last_q, NUM_REQ);
  end

  // A-channel mux from the selected master and per-master grant.
  always_comb begin
    sel_req   = 1'b0;
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    gnt_o     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (sel == arb_id_t'(k)) begin
        sel_req   = req_i[k];
        m_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        m_we_o    = we_i[k];
        m_be_o    = be_i[k*BE_W +: BE_W];
        m_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // No full-bypass: a same-cycle pop does not free a slot for this cycle.
    m_req_o = reset_n & sel_req & ~fifo_full;
    accept  = m_req_o & m_gnt_i;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      gnt_o[k] = accept & (sel == arb_id_t'(k));
    end
  end

  // R-channel demux to the master at the head of the ID FIFO.
  always_comb begin
    rvalid_o    = '0;
    rready_head = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (head == arb_id_t'(k)) begin
        rvalid_o[k] = reset_n & m_rvalid_i & ~fifo_empty;
        rready_head = rready_i[k];
      end
    end
    m_rready_o = reset_n & rready_head & ~fifo_empty;
    pop        = m_rvalid_i & m_rready_o;
  end

  assign rdata_o       = m_rdata_i;
  assign outstanding_o = reset_n ? fifo_count : '0;
  assign err_o         = reset_n & err_q;

  // Round-robin pointer, request lock and sticky error state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q     <= arb_id_t'(NUM_REQ - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= sel;
        lock_q <= 1'b0;
      end else if (lock_q && !sel_req) begin
        lock_q <= 1'b0;
      end else if (m_req_o && !m_gnt_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if ((lock_q && !sel_req) || (m_rvalid_i && fifo_empty)) begin
        err_q <= 1'b1;
      end
    end
  end

  uvma_obi_memory_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (head)
  );

endmodule

// File: tb/tb_uvma_obi_memory_rr_arbiter.sv
// Directed self-checking bench for uvma_obi_memory_rr_arbiter (2 masters, depth 4).
module tb_uvma_obi_memory_rr_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;

  localparam logic [AW-1:0] ADDR0  = 32'hAAAA_0000;
  localparam logic [AW-1:0] ADDR1  = 32'hBBBB_0004;
  localparam logic [DW-1:0] WDATA0 = 32'h1111_1111;
  localparam logic [DW-1:0] WDATA1 = 32'h2222_2222;

  logic                 clk;
  logic                 reset_n;
  logic [NR-1:0]        req_i;
  logic [NR-1:0]        gnt_o;
  logic [NR*AW-1:0]     addr_i;
  logic [NR-1:0]        we_i;
  logic [NR*DW/8-1:0]   be_i;
  logic [NR*DW-1:0]     wdata_i;
  logic [NR-1:0]        rvalid_o;
  logic [DW-1:0]        rdata_o;
  logic [NR-1:0]        rready_i;
  logic                 m_req_o;
  logic                 m_gnt_i;
  logic [AW-1:0]        m_addr_o;
  logic                 m_we_o;
  logic [DW/8-1:0]      m_be_o;
  logic [DW-1:0]        m_wdata_o;
  logic                 m_rvalid_i;
  logic [DW-1:0]        m_rdata_i;
  logic                 m_rready_o;
  logic [$clog2(MO+1)-1:0] outstanding_o;
  logic                 err_o;

  int unsigned n_cmp;
  int unsigned n_err;

  uvma_obi_memory_rr_arbiter #(
    .NUM_REQ         (NR),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .rready_i      (rready_i),
    .m_req_o       (m_req_o),
    .m_gnt_i       (m_gnt_i),
    .m_addr_o      (m_addr_o),
    .m_we_o        (m_we_o),
    .m_be_o        (m_be_o),
    .m_wdata_o     (m_wdata_o),
    .m_rvalid_i    (m_rvalid_i),
    .m_rdata_i     (m_rdata_i),
    .m_rready_o    (m_rready_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic gnt, input logic rv,
                       input logic [NR-1:0] rr, input logic [DW-1:0] rd);
    req_i      = req;
    m_gnt_i    = gnt;
    m_rvalid_i = rv;
    rready_i   = rr;
    m_rdata_i  = rd;
    #2;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    addr_i   = {ADDR1, ADDR0};
    wdata_i  = {WDATA1, WDATA0};
    we_i     = 2'b10;
    be_i     = 8'hF3;
    drive(2'b11, 1'b1, 1'b1, 2'b11, 32'h0);

    // Reset: all outputs held low even with active inputs.
    tick();
    drive(2'b11, 1'b1, 1'b1, 2'b11, 32'h0);
    check_val("rst_m_req", 64'(m_req_o), 64'd0);
    check_val("rst_gnt", 64'(gnt_o), 64'd0);
    check_val("rst_rvalid", 64'(rvalid_o), 64'd0);
    check_val("rst_m_rready", 64'(m_rready_o), 64'd0);
    check_val("rst_outst", 64'(outstanding_o), 64'd0);
    check_val("rst_err", 64'(err_o), 64'd0);
    tick();
    reset_n = 1'b1;

    // Fairness: both request, slave always grants -> 0,1,0,1 until full.
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
      check_val("fair_gnt", 64'(gnt_o), (i % 2 == 0) ? 64'd1 : 64'd2);
      check_val("fair_addr", 64'(m_addr_o), (i % 2 == 0) ? 64'(ADDR0) : 64'(ADDR1));
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
    check_val("full_m_req", 64'(m_req_o), 64'd0);
    check_val("full_gnt", 64'(gnt_o), 64'd0);
    check_val("full_outst", 64'(outstanding_o), 64'd4);

    // Drain: FIFO holds 0,1,0,1. Pop while full must not bypass.
    drive(2'b11, 1'b0, 1'b1, 2'b11, 32'hD000_0000);
    check_val("d1_rvalid", 64'(rvalid_o), 64'd1);
    check_val("d1_rdata", 64'(rdata_o), 64'hD000_0000);
    check_val("d1_m_rready", 64'(m_rready_o), 64'd1);
    check_val("d1_nobypass", 64'(m_req_o), 64'd0);
    tick();
    // Slot freed: m0 (last was 1) granted while head=1 pops.
    drive(2'b11, 1'b1, 1'b1, 2'b11, 32'hD000_0001);
    check_val("d2_rvalid", 64'(rvalid_o), 64'd2);
    check_val("d2_m_req", 64'(m_req_o), 64'd1);
    check_val("d2_gnt", 64'(gnt_o), 64'd1);
    check_val("d2_addr", 64'(m_addr_o), 64'(ADDR0));
    check_val("d2_outst", 64'(outstanding_o), 64'd3);
    tick();
    // Remaining FIFO order 0,1,0; count unchanged by push+pop.
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b11, 32'hD000_0010 + 32'(i));
      if (i == 0) check_val("d3_outst", 64'(outstanding_o), 64'd3);
      check_val("dn_rvalid", 64'(rvalid_o), (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("drain_outst", 64'(outstanding_o), 64'd0);
    check_val("drain_err", 64'(err_o), 64'd0);

    // Lock: m0 stalled 3 cycles while m1 joins (round-robin alone would pick m1).
    drive(2'b01, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("lk1_m_req", 64'(m_req_o), 64'd1);
    check_val("lk1_addr", 64'(m_addr_o), 64'(ADDR0));
    check_val("lk1_gnt", 64'(gnt_o), 64'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 1'b0, 1'b0, 2'b11, 32'h0);
      check_val("lk_addr", 64'(m_addr_o), 64'(ADDR0));
      check_val("lk_we", 64'(m_we_o), 64'd0);
      check_val("lk_gnt", 64'(gnt_o), 64'd0);
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
    check_val("lk4_gnt", 64'(gnt_o), 64'd1);
    check_val("lk4_wdata", 64'(m_wdata_o), 64'(WDATA0));
    tick();
    drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
    check_val("lk5_gnt", 64'(gnt_o), 64'd2);
    check_val("lk5_addr", 64'(m_addr_o), 64'(ADDR1));
    check_val("lk5_we", 64'(m_we_o), 64'd1);
    check_val("lk5_wdata", 64'(m_wdata_o), 64'(WDATA1));
    check_val("lk5_be", 64'(m_be_o), 64'hF);
    tick();

    // Routing: FIFO 0,1 -> D1 to m0, then D2 to m1 with m1 stalling 2 cycles.
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'hD1D1_D1D1);
    check_val("rt_outst", 64'(outstanding_o), 64'd2);
    check_val("rt1_rvalid", 64'(rvalid_o), 64'd1);
    check_val("rt1_rdata", 64'(rdata_o), 64'hD1D1_D1D1);
    check_val("rt1_m_rready", 64'(m_rready_o), 64'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b01, 32'hD2D2_D2D2);
      check_val("rt_stall_rvalid", 64'(rvalid_o), 64'd2);
      check_val("rt_stall_m_rready", 64'(m_rready_o), 64'd0);
      tick();
    end
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'hD2D2_D2D2);
    check_val("rt2_rvalid", 64'(rvalid_o), 64'd2);
    check_val("rt2_rdata", 64'(rdata_o), 64'hD2D2_D2D2);
    check_val("rt2_m_rready", 64'(m_rready_o), 64'd1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("rt_done_outst", 64'(outstanding_o), 64'd0);
    check_val("rt_done_err", 64'(err_o), 64'd0);

    // Reset mid-flight: two outstanding (last=1 -> m0 then m1).
    drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
    check_val("mf_gnt0", 64'(gnt_o), 64'd1);
    tick();
    drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
    check_val("mf_gnt1", 64'(gnt_o), 64'd2);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("mf_outst", 64'(outstanding_o), 64'd2);
    reset_n = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 2'b11, 32'h0);
    check_val("mf_rst_m_req", 64'(m_req_o), 64'd0);
    check_val("mf_rst_rvalid", 64'(rvalid_o), 64'd0);
    check_val("mf_rst_outst", 64'(outstanding_o), 64'd0);
    tick();
    reset_n = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("mf_post_outst", 64'(outstanding_o), 64'd0);
    check_val("mf_post_err", 64'(err_o), 64'd0);
    // Late response after reset is unexpected.
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'hDEAD_BEEF);
    check_val("ue_rvalid", 64'(rvalid_o), 64'd0);
    check_val("ue_m_rready", 64'(m_rready_o), 64'd0);
    check_val("ue_err_same", 64'(err_o), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
      check_val("ue_err_sticky", 64'(err_o), 64'd1);
      tick();
    end

    // Reset clears err; then the locked master withdrawing raises it again.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(2'b01, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("wd_err_clr", 64'(err_o), 64'd0);
    check_val("wd_m_req", 64'(m_req_o), 64'd1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("wd_err_same", 64'(err_o), 64'd0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
    check_val("wd_err", 64'(err_o), 64'd1);
    check_val("wd_outst", 64'(outstanding_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
